inst_fetch: RTL

//  Instruction fetch stage sitting directly upstream of mmu_axi. Generates sequential

---
 rtl/inst_fetch.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/inst_fetch.sv
// Instruction fetch stage: issues sequential word reads towards the MMU, keeps
// track of requests in flight, tags in-order returned words with their PC and
// buffers them for decode. A redirect retargets fetch and discards every
// response that belongs to requests made before the redirect.

// Simulation-only protocol checker: a returned word must match a request in flight.
module inst_fetch_chk #(
    parameter int CW = 3
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          rvalid_i,
    input  logic [CW-1:0] outstanding_i
);

    rvalid_needs_request: assert property (
        @(posedge clk_i) disable iff (!rst_n_i)
        rvalid_i |-> (outstanding_i != {CW{1'b0}})
    );

endmodule

module inst_fetch #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          DEPTH        = 4
) (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic        MEM_WAIT,
    output logic        INST_RDEN,
    output logic [31:0] INST_RADDR,
    input  logic        INST_RVALID,
    input  logic [31:0] INST_RDATA,
    input  logic        FLUSH,
    input  logic [31:0] NEW_PC,
    output logic        DEC_VALID,
    output logic [31:0] DEC_PC,
    output logic [31:0] DEC_INST,
    input  logic        DEC_READY
);

    localparam int          PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int          CW      = PW + 1;
    localparam logic [CW:0] DEPTH_L = (CW + 1)'(DEPTH);

    // request side
    logic          rden_q, rden_d;
    logic [31:0]   raddr_q, raddr_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic          stale_q, stale_d;
    // response bookkeeping
    logic [CW-1:0] out_q, out_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    // buffer
    logic [31:0]   mem_pc_q   [DEPTH];
    logic [31:0]   mem_inst_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    // decode-facing registers
    logic          dec_valid_q, dec_valid_d;
    logic [31:0]   dec_pc_q, dec_pc_d;
    logic [31:0]   dec_inst_q, dec_inst_d;

    logic          accept_s;
    logic          push_s;
    logic          pop_s;
    logic          drop_resp_s;
    logic [CW:0]   load_s;
    logic [CW-1:0] remain_s;
    logic [31:0]   new_pc_s;
    logic          unused_s;

    assign accept_s    = rden_q & ~MEM_WAIT;
    assign drop_resp_s = INST_RVALID & (drop_q != {CW{1'b0}});
    assign push_s      = INST_RVALID & (drop_q == {CW{1'b0}}) & ~FLUSH;
    assign pop_s       = dec_valid_q & DEC_READY & ~FLUSH;
    // slots already committed: in flight + buffered + the one handed over this edge
    assign load_s      = {1'b0, out_q} + {1'b0, count_q} + {{CW{1'b0}}, accept_s};
    assign remain_s    = count_q - CW'(pop_s);
    assign new_pc_s    = {NEW_PC[31:2], 2'b00};
    assign unused_s    = ^NEW_PC[1:0];

    // Request generation: hold while the MMU stalls, otherwise issue whenever a slot is free
    always_comb begin
        rden_d     = rden_q;
        raddr_d    = raddr_q;
        fetch_pc_d = fetch_pc_q;
        stale_d    = stale_q;
        if (rden_q && MEM_WAIT) begin
            // a stalled request cannot be retracted; on redirect remember it is stale
            if (FLUSH) begin
                stale_d    = 1'b1;
                fetch_pc_d = new_pc_s;
            end else begin
                stale_d    = stale_q;
            end
        end else if (FLUSH) begin
            rden_d     = 1'b0;
            fetch_pc_d = new_pc_s;
            stale_d    = 1'b0;
        end else begin
            stale_d = 1'b0;
            if (load_s < DEPTH_L) begin
                rden_d     = 1'b1;
                raddr_d    = fetch_pc_q;
                fetch_pc_d = fetch_pc_q + 32'd4;
            end else begin
                rden_d     = 1'b0;
            end
        end
    end

    // In-flight and discard accounting
    always_comb begin
        out_d  = out_q + CW'(accept_s) - CW'(INST_RVALID);
        drop_d = drop_q;
        if (FLUSH) begin
            // everything still in flight after this edge predates the redirect
            drop_d = out_d;
        end else begin
            drop_d = drop_q - CW'(drop_resp_s) + CW'(accept_s & stale_q);
        end
    end

    // Buffer pointers, fill level and the PC tag of the next returned word
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        resp_pc_d = resp_pc_q;
        if (FLUSH) begin
            wr_ptr_d  = {PW{1'b0}};
            rd_ptr_d  = {PW{1'b0}};
            count_d   = {CW{1'b0}};
            resp_pc_d = new_pc_s;
        end else begin
            wr_ptr_d  = wr_ptr_q + PW'(push_s);
            rd_ptr_d  = rd_ptr_q + PW'(pop_s);
            count_d   = count_q + CW'(push_s) - CW'(pop_s);
            if (push_s) begin
                resp_pc_d = resp_pc_q + 32'd4;
            end else begin
                resp_pc_d = resp_pc_q;
            end
        end
    end

    // Next head of the buffer as presented to decode; holds last word when empty
    always_comb begin
        dec_valid_d = dec_valid_q;
        dec_pc_d    = dec_pc_q;
        dec_inst_d  = dec_inst_q;
        if (FLUSH) begin
            dec_valid_d = 1'b0;
        end else begin
            dec_valid_d = (count_d != {CW{1'b0}});
            if (remain_s != {CW{1'b0}}) begin
                dec_pc_d   = mem_pc_q[rd_ptr_d];
                dec_inst_d = mem_inst_q[rd_ptr_d];
            end else if (push_s) begin
                // buffer was (or becomes) empty: the incoming word is the new head
                dec_pc_d   = resp_pc_q;
                dec_inst_d = INST_RDATA;
            end else begin
                dec_pc_d   = dec_pc_q;
                dec_inst_d = dec_inst_q;
            end
        end
    end

    // State registers
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            rden_q      <= 1'b0;
            raddr_q     <= RESET_VECTOR;
            fetch_pc_q  <= RESET_VECTOR;
            stale_q     <= 1'b0;
            out_q       <= {CW{1'b0}};
            drop_q      <= {CW{1'b0}};
            resp_pc_q   <= RESET_VECTOR;
            wr_ptr_q    <= {PW{1'b0}};
            rd_ptr_q    <= {PW{1'b0}};
            count_q     <= {CW{1'b0}};
            dec_valid_q <= 1'b0;
            dec_pc_q    <= 32'h0000_0000;
            dec_inst_q  <= 32'h0000_0000;
        end else begin
            rden_q      <= rden_d;
            raddr_q     <= raddr_d;
            fetch_pc_q  <= fetch_pc_d;
            stale_q     <= stale_d;
            out_q       <= out_d;
            drop_q      <= drop_d;
            resp_pc_q   <= resp_pc_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            dec_valid_q <= dec_valid_d;
            dec_pc_q    <= dec_pc_d;
            dec_inst_q  <= dec_inst_d;
        end
    end

    // Buffer storage, written on every accepted (non-discarded) response
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_pc_q[i]   <= 32'h0000_0000;
                mem_inst_q[i] <= 32'h0000_0000;
            end
        end else if (push_s) begin
            mem_pc_q[wr_ptr_q]   <= resp_pc_q;
            mem_inst_q[wr_ptr_q] <= INST_RDATA;
        end
    end

    assign INST_RDEN  = rden_q;
    assign INST_RADDR = raddr_q;
    assign DEC_VALID  = dec_valid_q;
    assign DEC_PC     = dec_pc_q;
    assign DEC_INST   = dec_inst_q;

    inst_fetch_chk #(.CW(CW)) u_chk (
        .clk_i         (CLK),
        .rst_n_i       (RSTN),
        .rvalid_i      (INST_RVALID),
        .outstanding_i (out_q)
    );

endmodule
